gsm_ts_fir: RTL
===============

// Module: gsm_ts_fir
// PURPOSE
//  Parametrised symmetric FIR; folded pre-add, SHARE-way time-shared multiplier bank, runtime-loadable coefficients.
//  Sits in the GSM pulse-shaping/receive chain between the sample-rate front end and the downstream symbol path.
//  Processes one input sample per sam_clk_en with a fixed-latency sequencer; flags samples arriving while busy.
// PARAMETERS
//  WIDTH   18   data and coefficient width; x_in/y are 1sWIDTH-1, coefs are 0sWIDTH
//  LENGTH  101  tap count; must be odd; HALF=(LENGTH+1)/2 unique coefs, index HALF-1 is the centre tap
//  SHARE   4    multiplier time-share factor; NMULT=ceil(HALF/SHARE) multipliers (13 at defaults)
//  ACC_W   44   accumulator width; must be >= 2*WIDTH+clog2(HALF)
// PORTS
//  sys_clk    in   1              system clock, all logic on rising edge
//  reset      in   1              asynchronous, active-high reset
//  sam_clk_en in   1              one-cycle strobe per input sample
//  x_in       in   WIDTH          signed 1sWIDTH-1 input sample
//  coef_we    in   1              coefficient write enable
//  coef_addr  in   clog2(HALF)    coefficient index 0..HALF-1
//  coef_data  in   WIDTH          signed 0sWIDTH coefficient
//  y          out  WIDTH          signed 1sWIDTH-1 filter output, registered, held between updates
//  y_valid    out  1              one-cycle pulse on each new y
//  busy       out  1              high while a sample is being computed
//  overrun    out  1              sticky; sam_clk_en seen while busy
// BEHAVIOUR
//  Reset (async): delay line, folded regs, product/tree pipes, acc, coefs, y cleared to 0; y_valid=busy=overrun=0; FSM->IDLE.
//  Delay line: on every sam_clk_en, x[0]<=x_in>>>1 (2sWIDTH-2), x[i]<=x[i-1]; shifts regardless of FSM state.
//  FSM: IDLE -> PREADD -> MAC(p=0..SHARE-1) -> DRAIN(2 cycles) -> OUT -> IDLE.
//   IDLE: sam_clk_en -> PREADD, busy<=1 (edge E0 = edge sampling the strobe).
//   PREADD (1 cyc): f[k]<=x[k]+x[LENGTH-1-k] for k<HALF-1; f[HALF-1]<=x[HALF-1]. Later shifts don't affect f.
//   MAC phase p: multiplier m uses f[m*SHARE+p] * coef[m*SHARE+p]; index >= HALF contributes 0.
//   Pipe: product reg (2*WIDTH, 2sWIDTH*2-2) -> registered adder tree over NMULT (full width) -> acc.
//   acc loads tree output on first valid phase, adds on the next SHARE-1; DRAIN covers 2 pipe stages.
//   OUT: y<=acc[2*WIDTH-2 -: WIDTH] (2s(2W-2) -> 1s(W-1)), y_valid<=1 for one cycle, busy<=0.
//  Latency: y/y_valid update on edge E0+SHARE+4 (E0+8 at defaults); min sample spacing SHARE+5 cycles.
//  sam_clk_en while busy: sample still shifted into delay line; no computation launched for it; overrun<=1.
//   No y_valid for that sample. overrun cleared only by reset.
//  sam_clk_en on the OUT cycle counts as busy (overrun); sam_clk_en on the first IDLE cycle after is accepted.
//  coef_we: coef[coef_addr]<=coef_data next edge, any state; coef_addr>=HALF ignored.
//   Write during MAC takes effect from next phase; result then mixes old/new coefs (allowed, undefined value).
//  Reset mid-operation: computation abandoned, y_valid never pulses for it; next sample after release is exact.
// CONFIGURATION
//  GSM_FIR_SAT_EN defined: acc outside 1sWIDTH-1 range clamps y to +2^(W-1)-1 / -2^(W-1) (0x1FFFF/0x20000).
//  GSM_FIR_SAT_EN undefined: y is plain bit-select of acc (wrap-around on overflow), no extra logic.
// TESTING
//  1 Assert reset mid-run with busy=1 -> y=0, y_valid=0, busy=0, overrun=0 immediately (no clock needed).
//  2 coef[k]=4*(k+1), k=0..50; impulse x_in=65536 then 0s, strobe every 12 clk -> y=1,2..51,50..1, then 0; y_valid 8 clk after each strobe.
//  3 All coef=131071, x_in=131071 constant -> SAT_EN: y settles 131071; without: y equals wrapped acc[34:17].
//  4 Strobes every 4 clk -> overrun=1 after 2nd strobe, y_valid only for every 3rd strobe, delay line holds all samples.
//  5 Reset asserted 3 clk after a strobe, released, new impulse -> no y_valid for aborted sample; next output matches test 2.
//  6 coef_we with coef_addr=51 (HALF) data=777 -> all coefs unchanged; test 2 response unchanged.

Source files
------------

// File: rtl/gsm_ts_fir.sv
// rtl/gsm_ts_fir.sv - symmetric FIR, folded pre-add, SHARE-way time-shared multiplier bank
// Optional output saturation when GSM_FIR_SAT_EN is defined; wrap-around otherwise.
module gsm_ts_fir #(
    parameter int WIDTH  = 18,
    parameter int LENGTH = 101,
    parameter int SHARE  = 4,
    parameter int ACC_W  = 44,
    localparam int HALF  = (LENGTH + 1) / 2,
    localparam int AW    = $clog2(HALF)
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    sam_clk_en,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic                    coef_we,
    input  logic [AW-1:0]           coef_addr,
    input  logic signed [WIDTH-1:0] coef_data,
    output logic signed [WIDTH-1:0] y,
    output logic                    y_valid,
    output logic                    busy,
    output logic                    overrun
);
    localparam int NMULT = (HALF + SHARE - 1) / SHARE;
    localparam int PW    = (SHARE > 2) ? $clog2(SHARE) : 1;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_MAC, S_DRAIN, S_OUT} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           phase_q, phase_d;
    logic signed [WIDTH-1:0] x_q    [LENGTH];
    logic signed [WIDTH-1:0] f_q    [HALF];
    logic signed [WIDTH-1:0] coef_q [HALF];
    logic signed [WIDTH-1:0] lane_f [NMULT][SHARE];
    logic signed [WIDTH-1:0] lane_c [NMULT][SHARE];
    logic signed [WIDTH-1:0] mul_f  [NMULT];
    logic signed [WIDTH-1:0] mul_c  [NMULT];
    logic signed [2*WIDTH-1:0] prod_d [NMULT];
    logic signed [2*WIDTH-1:0] prod_q [NMULT];
    logic signed [ACC_W-1:0] tree_d, tree_q, acc_q;
    logic                    prod_v_q, prod_first_q, tree_v_q, tree_first_q;
    logic signed [WIDTH-1:0] y_q, y_d;
    logic                    y_valid_q, busy_q, overrun_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        case (state_q)
            S_IDLE:  if (sam_clk_en) state_d = S_PRE;
            S_PRE: begin
                state_d = S_MAC;
                phase_d = '0;
            end
            S_MAC: begin
                if (phase_q == PW'(SHARE - 1)) begin
                    state_d = S_DRAIN;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (phase_q == PW'(1)) state_d = S_OUT;
                else                   phase_d = phase_q + 1'b1;
            end
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
        end
    end

    // Delay line shifts on every strobe, even while a computation is in flight.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LENGTH; i++) x_q[i] <= '0;
        end else if (sam_clk_en) begin
            x_q[0] <= x_in >>> 1;
            for (int i = 1; i < LENGTH; i++) x_q[i] <= x_q[i-1];
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < HALF; k++) f_q[k] <= '0;
        end else if (state_q == S_PRE) begin
            for (int k = 0; k < HALF - 1; k++) f_q[k] <= x_q[k] + x_q[LENGTH-1-k];
            f_q[HALF-1] <= x_q[HALF-1];
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < HALF; k++) coef_q[k] <= '0;
        end else if (coef_we && (int'(coef_addr) < HALF)) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    for (genvar m = 0; m < NMULT; m++) begin : g_lane
        for (genvar p = 0; p < SHARE; p++) begin : g_phase
            if (m * SHARE + p < HALF) begin : g_used
                assign lane_f[m][p] = f_q[m*SHARE+p];
                assign lane_c[m][p] = coef_q[m*SHARE+p];
            end else begin : g_pad
                assign lane_f[m][p] = '0;
                assign lane_c[m][p] = '0;
            end
        end
    end

    always_comb begin
        for (int m = 0; m < NMULT; m++) begin
            mul_f[m] = '0;
            mul_c[m] = '0;
            for (int p = 0; p < SHARE; p++) begin
                if (phase_q == PW'(p)) begin
                    mul_f[m] = lane_f[m][p];
                    mul_c[m] = lane_c[m][p];
                end
            end
            prod_d[m] = (2*WIDTH)'(mul_f[m]) * (2*WIDTH)'(mul_c[m]);
        end
    end

    always_comb begin
        tree_d = '0;
        for (int m = 0; m < NMULT; m++) tree_d = tree_d + ACC_W'(prod_q[m]);
    end

    // Phase tags ride along the pipe so the accumulator knows when to load vs add.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            for (int m = 0; m < NMULT; m++) prod_q[m] <= '0;
            tree_q       <= '0;
            acc_q        <= '0;
            prod_v_q     <= 1'b0;
            prod_first_q <= 1'b0;
            tree_v_q     <= 1'b0;
            tree_first_q <= 1'b0;
        end else begin
            for (int m = 0; m < NMULT; m++) prod_q[m] <= prod_d[m];
            prod_v_q     <= (state_q == S_MAC);
            prod_first_q <= (state_q == S_MAC) && (phase_q == '0);
            tree_q       <= tree_d;
            tree_v_q     <= prod_v_q;
            tree_first_q <= prod_first_q;
            if (tree_v_q) acc_q <= tree_first_q ? tree_q : acc_q + tree_q;
        end
    end

`ifdef GSM_FIR_SAT_EN
    logic [ACC_W-2*WIDTH+1:0] acc_top;
    always_comb begin
        acc_top = acc_q[ACC_W-1:2*WIDTH-2];
        if ((&acc_top) || !(|acc_top)) y_d = acc_q[2*WIDTH-2 -: WIDTH];
        else if (acc_q[ACC_W-1])       y_d = {1'b1, {(WIDTH-1){1'b0}}};
        else                           y_d = {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    assign y_d = acc_q[2*WIDTH-2 -: WIDTH];
`endif

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            y_valid_q <= (state_q == S_OUT);
            if (state_q == S_OUT) y_q <= y_d;
            busy_q    <= (state_d != S_IDLE);
            if (sam_clk_en && (state_q != S_IDLE)) overrun_q <= 1'b1;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;
endmodule
